// File: rtl/md_issue_if.sv
// Issue-controller bundle: pipeline request/response side plus the MultDiv side.
// The controller takes the master modport; the pipeline/MultDiv environment takes slave.
interface md_issue_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 3;

    logic            req_valid;
    logic [OPW-1:0]  req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            stall;
    logic            md_start;
    logic [OPW-1:0]  md_op;
    logic [XLEN-1:0] md_a;
    logic [XLEN-1:0] md_b;
    logic            md_busy;
    logic [XLEN-1:0] md_out;
    logic [XLEN-1:0] rd_data;
    logic            rd_valid;
    logic            timeout_err;

    modport master (
        input  req_valid, req_op, req_a, req_b, flush, md_busy, md_out,
        output stall, md_start, md_op, md_a, md_b, rd_data, rd_valid, timeout_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, flush, md_busy, md_out,
        input  stall, md_start, md_op, md_a, md_b, rd_data, rd_valid, timeout_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the iterative MultDiv unit: start pulse, operand hold,
// busy stall, zero-latency mfhi/mflo return and a sticky watchdog.
module md_issue_ctrl #(
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned WAIT_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    md_issue_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 3;
    localparam int unsigned WDW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BUSY} state_t;

    state_t          state;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            start_q;
    logic            terr_q;
    logic [WDW-1:0]  wdog;

    logic            req_live;
    logic            accept;
    logic            is_mf;
    logic            mf_hit;
    logic [WDW-1:0]  wdog_nxt;

    // Request qualification; mfhi/mflo are served straight from md_out without a start.
    always_comb begin
        req_live = bus.req_valid & ~bus.flush;
        accept   = req_live & (state == IDLE);
        is_mf    = (bus.req_op[2:1] == 2'b10);
        mf_hit   = accept & is_mf;
        wdog_nxt = wdog + WDW'(1);
    end

    assign bus.stall       = req_live & (state != IDLE);
    assign bus.rd_valid    = mf_hit;
    assign bus.rd_data     = mf_hit ? bus.md_out : '0;
    assign bus.md_op       = mf_hit ? bus.req_op : op_q;
    assign bus.md_a        = a_q;
    assign bus.md_b        = b_q;
    assign bus.md_start    = start_q;
    assign bus.timeout_err = terr_q;

    // Single-process FSM; start_q is high exactly for the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            wdog    <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.req_op;
                        if (!is_mf) begin
                            a_q     <= bus.req_a;
                            b_q     <= bus.req_b;
                            start_q <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    // Only compute and mthi/mtlo reach ISSUE; op[2] set means a move-to.
                    state <= op_q[2] ? IDLE : WAIT;
                end
                WAIT, BUSY: begin
                    wdog <= wdog_nxt;
                    // Normal completion wins over the watchdog on the same cycle.
                    if (state == WAIT && !bus.md_busy && wdog_nxt == WDW'(WAIT_MAX)) begin
                        state <= IDLE;
                    end else if (state == BUSY && !bus.md_busy) begin
                        state <= IDLE;
                    end else if (wdog_nxt == WDW'(TIMEOUT)) begin
                        terr_q <= 1'b1;
                        state  <= IDLE;
                    end else if (state == WAIT && bus.md_busy) begin
                        state <= BUSY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural MultDiv (fixed latency, hi/lo).
module tb_md_issue_ctrl;
    localparam int unsigned MD_LAT = 4;
    localparam logic [2:0] OP_MULT = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;
    localparam logic [2:0] OP_MTHI = 3'b110;

    logic clk;
    logic rst_n;
    logic force_busy;
    int   n_checks;
    int   n_errors;

    md_issue_if bus ();

    md_issue_ctrl #(.TIMEOUT(8), .WAIT_MAX(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MultDiv: busy for MD_LAT cycles after a compute start; mthi/mtlo immediate.
    logic        busy_m;
    logic [3:0]  cnt_m;
    logic [31:0] hi_m, lo_m, pend_hi, pend_lo, res_hi, res_lo;
    logic [63:0] prod;

    always_comb begin
        prod   = '0;
        res_hi = '0;
        res_lo = '0;
        case (bus.md_op)
            3'b000: begin
                prod = $signed({{32{bus.md_a[31]}}, bus.md_a}) * $signed({{32{bus.md_b[31]}}, bus.md_b});
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            3'b001: begin
                prod = {32'd0, bus.md_a} * {32'd0, bus.md_b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            3'b010: if (bus.md_b != 0) begin
                res_lo = $signed(bus.md_a) / $signed(bus.md_b);
                res_hi = $signed(bus.md_a) % $signed(bus.md_b);
            end
            3'b011: if (bus.md_b != 0) begin
                res_lo = bus.md_a / bus.md_b;
                res_hi = bus.md_a % bus.md_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0; cnt_m <= '0; hi_m <= '0; lo_m <= '0; pend_hi <= '0; pend_lo <= '0;
        end else if (busy_m) begin
            cnt_m <= cnt_m - 4'd1;
            if (cnt_m == 4'd1) begin
                busy_m <= 1'b0;
                hi_m   <= pend_hi;
                lo_m   <= pend_lo;
            end
        end else if (bus.md_start) begin
            if (bus.md_op == 3'b110) hi_m <= bus.md_a;
            else if (bus.md_op == 3'b111) lo_m <= bus.md_a;
            else begin
                busy_m  <= 1'b1;
                cnt_m   <= 4'(MD_LAT);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
        end
    end

    assign bus.md_busy = busy_m | force_busy;
    assign bus.md_out  = (bus.md_op == 3'b100) ? hi_m : lo_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's request at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.flush     = f;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int stall_cnt;
        int bad;
        int tmo_k;
        n_checks = 0;
        n_errors = 0;
        force_busy = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULT;
        bus.req_a     = 32'hA5A5_A5A5;
        bus.req_b     = 32'h0000_0003;
        bus.flush     = 1'b0;

        // Reset state, with a request held during reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_start", 32'(bus.md_start), 32'd0);
        check("rst_op", 32'(bus.md_op), 32'd0);
        check("rst_a", bus.md_a, 32'd0);
        check("rst_b", bus.md_b, 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_terr", 32'(bus.timeout_err), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // 1: mult -2*5, single start pulse, then mflo/mfhi
        drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd5, 1'b0);
        check("t1_stall_acc", 32'(bus.stall), 32'd0);
        check("t1_start_t", 32'(bus.md_start), 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        check("t1_start_t1", 32'(bus.md_start), 32'd1);
        check("t1_op", 32'(bus.md_op), 32'd0);
        check("t1_a", bus.md_a, 32'hFFFF_FFFE);
        check("t1_b", bus.md_b, 32'd5);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        check("t1_start_t2", 32'(bus.md_start), 32'd0);
        repeat (8) drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        check("t1_mflo_stall", 32'(bus.stall), 32'd0);
        check("t1_mflo_valid", 32'(bus.rd_valid), 32'd1);
        check("t1_mflo_data", bus.rd_data, 32'hFFFF_FFF6);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        check("t1_mfhi_stall", 32'(bus.stall), 32'd0);
        check("t1_mfhi_valid", 32'(bus.rd_valid), 32'd1);
        check("t1_mfhi_data", bus.rd_data, 32'hFFFF_FFFF);
        check("t1_mfhi_start", 32'(bus.md_start), 32'd0);

        // 2: div 7/2, mfhi held behind it stalls ISSUE+WAIT+busy+drop cycle
        drive(1'b1, OP_DIV, 32'd7, 32'd2, 1'b0);
        check("t2_stall_acc", 32'(bus.stall), 32'd0);
        stall_cnt = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
            if (bus.md_busy && !bus.stall) bad++;
            if (!bus.stall) break;
            stall_cnt++;
        end
        check("t2_released", 32'(bus.stall), 32'd0);
        check("t2_stall_cycles", 32'(stall_cnt), 32'd6);
        check("t2_busy_nostall", 32'(bad), 32'd0);
        check("t2_mfhi_valid", 32'(bus.rd_valid), 32'd1);
        check("t2_mfhi_data", bus.rd_data, 32'd1);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        check("t2_mflo_stall", 32'(bus.stall), 32'd0);
        check("t2_mflo_data", bus.rd_data, 32'd3);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);

        // 3: mthi, one start pulse, next request not stalled
        drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check("t3_stall_acc", 32'(bus.stall), 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        check("t3_start", 32'(bus.md_start), 32'd1);
        check("t3_op", 32'(bus.md_op), 32'd6);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        check("t3_start_off", 32'(bus.md_start), 32'd0);
        check("t3_stall", 32'(bus.stall), 32'd0);
        check("t3_mfhi_data", bus.rd_data, 32'h1234_5678);

        // 4: flushed mult in IDLE is dropped
        drive(1'b1, OP_MULT, 32'hDEAD_BEEF, 32'd1, 1'b1);
        check("t4_stall", 32'(bus.stall), 32'd0);
        check("t4_rd_valid", 32'(bus.rd_valid), 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        check("t4_start", 32'(bus.md_start), 32'd0);
        check("t4_a_hold", bus.md_a, 32'h1234_5678);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        check("t4_idle", 32'(bus.stall), 32'd0);
        check("t4_mflo_data", bus.rd_data, 32'd3);

        // 5: busy stuck high -> watchdog after 8 WAIT/BUSY cycles
        force_busy = 1'b1;
        drive(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
        tmo_k = 0;
        for (int k = 1; k <= 40; k++) begin
            drive(k == 3 || k == 4, OP_MFHI, 32'd0, 32'd0, k == 3);
            if (k == 3) check("t5_flush_nostall", 32'(bus.stall), 32'd0);
            if (k == 4) check("t5_busy_stall", 32'(bus.stall), 32'd1);
            if (bus.timeout_err) begin
                tmo_k = k;
                break;
            end
        end
        check("t5_terr", 32'(bus.timeout_err), 32'd1);
        check("t5_terr_cycle", 32'(tmo_k), 32'd10);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        check("t5_idle", 32'(bus.stall), 32'd0);
        force_busy = 1'b0;
        repeat (5) drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        check("t5_sticky", 32'(bus.timeout_err), 32'd1);

        // 6: async reset in BUSY
        drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        check("t6_busy_stall", 32'(bus.stall), 32'd1);
        #2;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_start", 32'(bus.md_start), 32'd0);
        check("t6_op", 32'(bus.md_op), 32'd0);
        check("t6_a", bus.md_a, 32'd0);
        check("t6_b", bus.md_b, 32'd0);
        check("t6_terr", 32'(bus.timeout_err), 32'd0);
        check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t6_rd_data", bus.rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        check("t6_stall_rel", 32'(bus.stall), 32'd0);
        check("t6_mfhi_valid", 32'(bus.rd_valid), 32'd1);
        check("t6_mfhi_data", bus.rd_data, 32'd0);
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
